// File: rtl/snn_pkg.sv
// Shared SNN constants and the spike-time type used by the encoder, the layer and the benches.
package snn_pkg;

  localparam int NUM_INPUTS  = 64;
  localparam int PIX_W       = 8;
  localparam int TIME_PERIOD = 8;
  localparam int LOG_TP      = 3;
  localparam int THRESH      = 32;

  typedef logic [LOG_TP:0] spike_t;

  // TIME_PERIOD is one past the last usable slot, so it doubles as "never fires".
  localparam spike_t NO_SPIKE = spike_t'(TIME_PERIOD);

endpackage

// File: rtl/spike_frame_encoder_encode.sv
// Pixel intensity to temporal spike time: brighter pixels fire earlier, dim ones never fire.
module spike_time_encode #(
  parameter int PIX_W  = 8,
  parameter int LOG_TP = 3,
  parameter int THRESH = 32
) (
  input  logic [PIX_W-1:0] pix,
  output logic [LOG_TP:0]  t
);

  localparam logic [PIX_W-1:0]  PIX_MAX = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0]  THR     = PIX_W'(THRESH);
  localparam logic [LOG_TP:0]   NO_SPK  = (LOG_TP+1)'(2**LOG_TP);

  logic [PIX_W-1:0] inv;

  // Invert the intensity and keep its top LOG_TP bits as the firing slot.
  always_comb begin
    inv = PIX_MAX - pix;
    if (pix < THR) begin
      t = NO_SPK;
    end else begin
      t = (LOG_TP+1)'(inv >> (PIX_W - LOG_TP));
    end
  end

endmodule

// File: rtl/spike_frame_encoder.sv
// Double-buffered frame encoder: fills spike times from a pixel stream and swaps the
// displayed frame only on the time_val wrap so every layer period sees one whole frame.
module spike_frame_encoder
  import snn_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LOG_TP:0]                  time_val,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic [PIX_W-1:0]                 pix_data,
  input  logic                             pix_last,
  output logic [NUM_INPUTS*(LOG_TP+1)-1:0] spike_times,
  output logic                             frame_valid,
  output logic                             frame_start,
  output logic                             frame_err
);

  localparam int              IDX_W    = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam spike_t          WRAP_TV  = spike_t'(TIME_PERIOD - 1);

  spike_t           fill_buf [NUM_INPUTS];
  spike_t           disp_buf [NUM_INPUTS];
  logic [IDX_W-1:0] fill_idx;
  logic             fill_full;
  spike_t           enc_t;
  logic             accept;
  logic             at_last;
  logic             swap;

  spike_time_encode #(
    .PIX_W  (PIX_W),
    .LOG_TP (LOG_TP),
    .THRESH (THRESH)
  ) u_encode (
    .pix (pix_data),
    .t   (enc_t)
  );

  // Ready depends only on registered state; swap uses the pre-edge fill_full so a
  // frame completing on the wrap edge itself waits a full period.
  assign pix_ready = !fill_full;
  assign accept    = pix_valid && !fill_full;
  assign at_last   = (fill_idx == LAST_IDX);
  assign swap      = fill_full && (time_val == WRAP_TV);

  // Fill index, fill-full flag and sticky framing error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_idx  <= '0;
      fill_full <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (swap) begin
        fill_full <= 1'b0;
      end else if (accept) begin
        if (at_last && pix_last) begin
          fill_full <= 1'b1;
          fill_idx  <= '0;
        end else if (at_last || pix_last) begin
          frame_err <= 1'b1;
          fill_idx  <= '0;
        end else begin
          fill_idx  <= fill_idx + IDX_W'(1);
        end
      end
    end
  end

  // Fill buffer holds already-encoded spike times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        fill_buf[i] <= NO_SPIKE;
      end
    end else if (accept) begin
      fill_buf[fill_idx] <= enc_t;
    end
  end

  // Displayed frame and its status flags; frame_start marks the time_val==0 cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        disp_buf[i] <= NO_SPIKE;
      end
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= swap;
      if (swap) begin
        disp_buf    <= fill_buf;
        frame_valid <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_out
    assign spike_times[g*(LOG_TP+1) +: (LOG_TP+1)] = disp_buf[g];
  end

endmodule

// File: tb/tb_spike_frame_encoder.sv
// Scoreboard bench: driver predicts each frame's contents and swap cycle, a monitor checks outputs.
module tb_spike_frame_encoder;
  import snn_pkg::*;

  localparam int SW = LOG_TP + 1;
  localparam int VW = NUM_INPUTS * SW;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic [LOG_TP:0] time_val  = '0;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [PIX_W-1:0] pix_data = '0;
  logic            pix_last  = 1'b0;
  logic [VW-1:0]   spike_times;
  logic            frame_valid;
  logic            frame_start;
  logic            frame_err;

  spike_frame_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .time_val    (time_val),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .spike_times (spike_times),
    .frame_valid (frame_valid),
    .frame_start (frame_start),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    int            due;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [VW-1:0] disp_exp;
  logic [VW-1:0] fill_model;
  int            fill_cnt = 0;
  bit            full_exp = 1'b0;
  bit            fv_exp   = 1'b0;
  bit            err_exp  = 1'b0;

  // Free-running period counter; changes 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    time_val = SW'((int'(time_val) + 1) % TIME_PERIOD);
  end

  function automatic logic [SW-1:0] model_enc(input int p);
    if (p < THRESH) return SW'(TIME_PERIOD);
    return SW'(((2**PIX_W) - 1 - p) / ((2**PIX_W) / TIME_PERIOD));
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, want);
    end
  endtask

  // Spec-level framing model, applied to every accepted beat.
  task automatic model_beat(input int p, input bit last, input int tvs, input int cs);
    fill_model[fill_cnt*SW +: SW] = model_enc(p);
    if (last && fill_cnt == NUM_INPUTS - 1) begin
      full_exp = 1'b1;
      q.push_back('{vec: fill_model,
                    due: cs + 1 + ((tvs == TIME_PERIOD - 1) ? TIME_PERIOD : TIME_PERIOD - 1 - tvs)});
      fill_cnt = 0;
    end else if (last || fill_cnt == NUM_INPUTS - 1) begin
      err_exp  = 1'b1;
      fill_cnt = 0;
    end else begin
      fill_cnt++;
    end
  endtask

  task automatic send_beat(input int p, input bit last);
    int tvs;
    int cs;
    bit rdy;
    int waited;
    waited    = 0;
    rdy       = 1'b0;
    tvs       = 0;
    cs        = 0;
    pix_valid = 1'b1;
    pix_data  = PIX_W'(p);
    pix_last  = last;
    forever begin
      @(negedge clk);
      rdy = pix_ready;
      tvs = int'(time_val);
      cs  = cyc;
      @(posedge clk);
      #2;
      if (rdy) break;
      waited++;
      if (waited > 4 * TIME_PERIOD) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout cyc=%0d actual=stalled expected=accepted", cyc);
        break;
      end
    end
    if (rdy) model_beat(p, last, tvs, cs);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int pix[NUM_INPUTS], input int last_tv);
    for (int i = 0; i < NUM_INPUTS - 1; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_beat(pix[i], 1'b0);
    end
    if (last_tv >= 0) begin
      for (int k = 0; k < TIME_PERIOD && int'(time_val) != last_tv; k++) idle(1);
    end
    send_beat(pix[NUM_INPUTS-1], 1'b1);
  endtask

  task automatic rand_frame(output int pix[NUM_INPUTS]);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      case ($urandom_range(0, 9))
        0:       pix[i] = THRESH - 1;
        1:       pix[i] = THRESH;
        2:       pix[i] = (2**PIX_W) - 1;
        default: pix[i] = int'($urandom_range(0, (2**PIX_W) - 1));
      endcase
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || full_exp) && n < 3 * TIME_PERIOD) begin
      idle(1);
      n++;
    end
    if (q.size() != 0 || full_exp) begin
      checks++;
      errors++;
      $display("FAIL swap_timeout cyc=%0d actual=pending expected=displayed", cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    pix_valid = 1'b0;
    q.delete();
    disp_exp  = {NUM_INPUTS{NO_SPIKE}};
    fv_exp    = 1'b0;
    full_exp  = 1'b0;
    err_exp   = 1'b0;
    fill_cnt  = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every frame_start and checks all outputs each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_start) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_frame_start cyc=%0d actual=1 expected=0", cyc);
        end else begin
          e = q.pop_front();
          chk("swap_cycle", VW'(cyc), VW'(e.due));
          disp_exp = e.vec;
          fv_exp   = 1'b1;
          full_exp = 1'b0;
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        checks++;
        errors++;
        $display("FAIL missed_swap cyc=%0d actual=none expected_at=%0d", cyc, q[0].due);
        e = q.pop_front();
        disp_exp = e.vec;
        fv_exp   = 1'b1;
        full_exp = 1'b0;
      end
      chk("spike_times", spike_times, disp_exp);
      chk("frame_valid", VW'(frame_valid), VW'(fv_exp));
      chk("pix_ready",   VW'(pix_ready),   VW'(!full_exp));
      chk("frame_err",   VW'(frame_err),   VW'(err_exp));
    end
  end

  initial begin
    int pix[NUM_INPUTS];
    logic [VW-1:0] snap;
    disp_exp = {NUM_INPUTS{NO_SPIKE}};
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed encode frame.
    for (int i = 0; i < NUM_INPUTS; i++) pix[i] = 0;
    pix[0] = 255; pix[1] = 128; pix[2] = 32; pix[3] = 31;
    send_frame(pix, -1);
    wait_idle();
    snap = spike_times;
    chk("encode_directed", VW'(snap[5*SW-1:0]), VW'(20'h88630));

    // Wrap alignment: mid-period and on the wrap edge itself.
    rand_frame(pix); send_frame(pix, 3); wait_idle();
    rand_frame(pix); send_frame(pix, TIME_PERIOD - 1); wait_idle();

    // Back-to-back frames under backpressure.
    for (int f = 0; f < 3; f++) begin
      rand_frame(pix);
      send_frame(pix, -1);
    end
    wait_idle();

    // Hold for three periods with no new frame.
    idle(3 * TIME_PERIOD);

    // Early pix_last, then a good frame.
    for (int i = 0; i < 9; i++) send_beat(int'($urandom_range(0, 255)), 1'b0);
    send_beat(200, 1'b1);
    rand_frame(pix); send_frame(pix, -1); wait_idle();

    // Missing pix_last on the final beat, then a good frame.
    do_reset();
    for (int i = 0; i < NUM_INPUTS; i++) send_beat(int'($urandom_range(0, 255)), 1'b0);
    rand_frame(pix); send_frame(pix, -1); wait_idle();

    // Reset mid-fill, then a fresh frame.
    for (int i = 0; i < 20; i++) send_beat(int'($urandom_range(0, 255)), 1'b0);
    do_reset();
    rand_frame(pix); send_frame(pix, -1); wait_idle();

    // Reset while a frame is displayed, then a fresh frame.
    idle(5);
    do_reset();
    idle(2);
    rand_frame(pix); send_frame(pix, -1); wait_idle();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
